data_mem_banked: RTL

DATA_MEM_BANKED -- requirements
Module: data_mem_banked

---
 rtl/data_mem_pkg.sv | 27 ++
 rtl/mem_bank.sv | 39 +++
 rtl/data_mem_banked.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared widths and encodings for the banked halfword data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  // How the two bank read registers are assembled onto o_data_out.
  typedef enum logic [2:0] {
    OUT_LO_EVEN  = 3'd0,
    OUT_LO_ODD   = 3'd1,
    OUT_W32_EVEN = 3'd2,
    OUT_W32_ODD  = 3'd3,
    OUT_ZERO     = 3'd4
  } out_sel_e;

endpackage
`default_nettype wire

// File: rtl/mem_bank.sv
`default_nettype none
// ============================================================================
// Module      : mem_bank
// Description : Single-port halfword RAM, synchronous write and registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bank
  import data_mem_pkg::*;
#(
  parameter int unsigned IDX_W = 19
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [HALF_W-1:0] i_wdata,
  output logic [HALF_W-1:0] o_rdata
);

  localparam int unsigned c_depth = 2**IDX_W;

  logic [HALF_W-1:0] mem_q [c_depth];
  logic [HALF_W-1:0] rdata_q;

  // The read register only moves on reads so it keeps presenting the last word.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        mem_q[i_addr] <= i_wdata;
      end else begin
        rdata_q <= mem_q[i_addr];
      end
    end
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_banked.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_banked
// Description : Halfword-addressed data memory split into even/odd banks with
//               16/32-bit little-endian access; odd 32-bit accesses take two
//               cycles. Define DATA_MEM_BOUNDS_CHK_EN to fault addresses >= LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_banked
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned LIMIT  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic              i_en32,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [WORD_W-1:0] i_data_in,
  output logic              o_ready,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_data_out,
  output logic              o_err
);

  localparam int unsigned   c_idx_w = ADDR_W - 1;
  localparam logic [ADDR_W:0] c_limit = (ADDR_W+1)'(LIMIT);
`ifdef DATA_MEM_BOUNDS_CHK_EN
  localparam logic c_chk_en = 1'b1;
`else
  localparam logic c_chk_en = 1'b0;
`endif

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                rd_q, rd_d;
  out_sel_e            sel_q, sel_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [c_idx_w-1:0]  pend_idx_q, pend_idx_d;
  logic [HALF_W-1:0]   pend_hi_q, pend_hi_d;
  logic                pend_we_q, pend_we_d;
  logic                pend_err_q, pend_err_d;

  logic [ADDR_W-1:0]   w_addr1;
  logic [c_idx_w-1:0]  w_idx0;
  logic                w_acc, w_split, w_oob;
  logic [WORD_W-1:0]   w_rdata;

  logic                w_ev_en, w_ev_we, w_od_en, w_od_we;
  logic [c_idx_w-1:0]  w_ev_addr, w_od_addr;
  logic [HALF_W-1:0]   w_ev_wdata, w_od_wdata, w_ev_rdata, w_od_rdata;

  assign w_addr1 = i_address + 1'b1;
  assign w_idx0  = i_address[ADDR_W-1:1];
  assign w_acc   = i_req & ready_q;
  assign w_split = i_en32 & i_address[0];
  // Both halves are checked up front so a faulting split access never writes either bank.
  assign w_oob   = c_chk_en & (({1'b0, i_address} >= c_limit) |
                               (i_en32 & ({1'b0, w_addr1} >= c_limit)));

  always_comb begin
    unique case (sel_q)
      OUT_LO_EVEN:  w_rdata = {{HALF_W{1'b0}}, w_ev_rdata};
      OUT_LO_ODD:   w_rdata = {{HALF_W{1'b0}}, w_od_rdata};
      OUT_W32_EVEN: w_rdata = {w_od_rdata, w_ev_rdata};
      OUT_W32_ODD:  w_rdata = {w_ev_rdata, w_od_rdata};
      default:      w_rdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    rd_d       = 1'b0;
    sel_d      = sel_q;
    hold_d     = rd_q ? w_rdata : hold_q;
    pend_idx_d = pend_idx_q;
    pend_hi_d  = pend_hi_q;
    pend_we_d  = pend_we_q;
    pend_err_d = pend_err_q;
    w_ev_en    = 1'b0;
    w_ev_we    = 1'b0;
    w_ev_addr  = w_idx0;
    w_ev_wdata = i_data_in[HALF_W-1:0];
    w_od_en    = 1'b0;
    w_od_we    = 1'b0;
    w_od_addr  = w_idx0;
    w_od_wdata = i_data_in[HALF_W-1:0];

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (w_acc) begin
          w_ev_en = ~w_split & ~i_address[0];
          w_ev_we = i_we & ~w_oob;
          w_od_en = i_address[0] | i_en32;
          w_od_we = i_we & ~w_oob;
          if (i_en32 && !i_address[0]) begin
            w_od_wdata = i_data_in[WORD_W-1:HALF_W];
          end
          if (w_split) begin
            state_d    = ST_SPLIT;
            ready_d    = 1'b0;
            pend_idx_d = w_idx0 + 1'b1;
            pend_hi_d  = i_data_in[WORD_W-1:HALF_W];
            pend_we_d  = i_we;
            pend_err_d = w_oob;
          end else begin
            valid_d = 1'b1;
            err_d   = w_oob;
            rd_d    = ~i_we;
            if (!i_we) begin
              if (w_oob)       sel_d = OUT_ZERO;
              else if (i_en32) sel_d = OUT_W32_EVEN;
              else             sel_d = i_address[0] ? OUT_LO_ODD : OUT_LO_EVEN;
            end
          end
        end
      end
      ST_SPLIT: begin
        w_ev_en    = 1'b1;
        w_ev_we    = pend_we_q & ~pend_err_q;
        w_ev_addr  = pend_idx_q;
        w_ev_wdata = pend_hi_q;
        valid_d    = 1'b1;
        err_d      = pend_err_q;
        rd_d       = ~pend_we_q;
        if (!pend_we_q) begin
          sel_d = pend_err_q ? OUT_ZERO : OUT_W32_ODD;
        end
        state_d    = ST_IDLE;
        ready_d    = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
      sel_q      <= OUT_ZERO;
      hold_q     <= '0;
      pend_idx_q <= '0;
      pend_hi_q  <= '0;
      pend_we_q  <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      pend_idx_q <= pend_idx_d;
      pend_hi_q  <= pend_hi_d;
      pend_we_q  <= pend_we_d;
      pend_err_q <= pend_err_d;
    end
  end

  mem_bank #(.IDX_W(c_idx_w)) u_bank_even (
    .clk     (clk),
    .i_en    (w_ev_en),
    .i_we    (w_ev_we),
    .i_addr  (w_ev_addr),
    .i_wdata (w_ev_wdata),
    .o_rdata (w_ev_rdata)
  );

  mem_bank #(.IDX_W(c_idx_w)) u_bank_odd (
    .clk     (clk),
    .i_en    (w_od_en),
    .i_we    (w_od_we),
    .i_addr  (w_od_addr),
    .i_wdata (w_od_wdata),
    .o_rdata (w_od_rdata)
  );

  // Fresh data is shown in the completion cycle, then held from hold_q.
  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign o_data_out = rd_q ? w_rdata : hold_q;

endmodule
`default_nettype wire
